// File: rtl/sync_width_fifo.sv
// Synchronous FIFO whose write and read ports may differ in width.
// Storage is a ring of narrow slots; wide words occupy consecutive slots, LSB slice first.
module sync_width_fifo #(
  parameter int unsigned DATAINWIDTH     = 8,
  parameter int unsigned DATAOUTWIDTH    = 32,
  parameter int unsigned MEMORYSIZE      = 1024,
  parameter int unsigned READMODE        = 0,
  parameter int unsigned PROGFULLTHRESH  = MEMORYSIZE / DATAINWIDTH - 8,
  parameter int unsigned PROGEMPTYTHRESH = 2
) (
  input  logic                                          clkIn,
  input  logic                                          rstIn,
  input  logic [DATAINWIDTH-1:0]                        fifoDataIn,
  input  logic                                          fifoWriteEn,
  input  logic                                          fifoReadEn,
  output logic [DATAOUTWIDTH-1:0]                       fifoDataOut,
  output logic                                          fifoDataOutValid,
  output logic                                          fifoRstDone,
  output logic                                          fifoEmpty,
  output logic                                          fifoFull,
  output logic                                          fifoProgEmpty,
  output logic                                          fifoProgFull,
  output logic                                          fifoOverflow,
  output logic                                          fifoUnderflow,
  output logic [$clog2(MEMORYSIZE/DATAOUTWIDTH):0]      fifoDataCount
);

  localparam int unsigned MIN_W  = (DATAINWIDTH < DATAOUTWIDTH) ? DATAINWIDTH : DATAOUTWIDTH;
  localparam int unsigned RIN    = DATAINWIDTH / MIN_W;
  localparam int unsigned ROUT   = DATAOUTWIDTH / MIN_W;
  localparam int unsigned SLOTS  = MEMORYSIZE / MIN_W;
  localparam int unsigned PTR_W  = $clog2(SLOTS);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned DCNT_W = $clog2(MEMORYSIZE / DATAOUTWIDTH) + 1;

  logic [MIN_W-1:0]        mem_q [SLOTS];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        used_q, used_d;
  logic [DCNT_W-1:0]       dcnt_q, dcnt_d;
  logic                    empty_q, empty_d, full_q, full_d;
  logic                    pempty_q, pempty_d, pfull_q, pfull_d;
  logic                    ovf_q, ovf_d, unf_q, unf_d;
  logic                    valid_q, valid_d;
  logic [DATAOUTWIDTH-1:0] dout_q, dout_d;
  logic [1:0]              rst_cnt_q, rst_cnt_d;
  logic                    rst_done_q, rst_done_d;
  logic                    wr_acc, rd_acc;
  logic [DATAOUTWIDTH-1:0] head_word;

  // Assemble the oldest output word from ROUT consecutive slots.
  always_comb begin
    head_word = '0;
    for (int unsigned k = 0; k < ROUT; k++) begin
      head_word[k*MIN_W +: MIN_W] = mem_q[PTR_W'(rd_ptr_q + PTR_W'(k))];
    end
  end

  always_comb begin
    wr_acc     = fifoWriteEn && !full_q && rst_done_q;
    rd_acc     = fifoReadEn && !empty_q && rst_done_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    used_d     = used_q;
    dout_d     = dout_q;
    valid_d    = rd_acc;
    ovf_d      = fifoWriteEn && full_q && rst_done_q;
    unf_d      = fifoReadEn && empty_q && rst_done_q;
    rst_cnt_d  = (rst_cnt_q == 2'd2) ? rst_cnt_q : rst_cnt_q + 2'd1;
    rst_done_d = rst_done_q || (rst_cnt_q == 2'd1);

    // Slot depth is a multiple of RIN and ROUT, so a word never straddles the wrap.
    if (wr_acc) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(SLOTS - RIN)) ? '0 : wr_ptr_q + PTR_W'(RIN);
      used_d   = used_d + CNT_W'(RIN);
    end
    if (rd_acc) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(SLOTS - ROUT)) ? '0 : rd_ptr_q + PTR_W'(ROUT);
      used_d   = used_d - CNT_W'(ROUT);
      dout_d   = head_word;
    end

    full_d   = (CNT_W'(SLOTS) - used_d) < CNT_W'(RIN);
    empty_d  = used_d < CNT_W'(ROUT);
    dcnt_d   = DCNT_W'(used_d / CNT_W'(ROUT));
    pfull_d  = 32'(used_d) >= PROGFULLTHRESH * RIN;
    pempty_d = 32'(dcnt_d) <= PROGEMPTYTHRESH;
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      used_q     <= '0;
      dcnt_q     <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      pempty_q   <= 1'b1;
      pfull_q    <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      valid_q    <= 1'b0;
      dout_q     <= '0;
      rst_cnt_q  <= '0;
      rst_done_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      used_q     <= used_d;
      dcnt_q     <= dcnt_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      pempty_q   <= pempty_d;
      pfull_q    <= pfull_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      valid_q    <= valid_d;
      dout_q     <= dout_d;
      rst_cnt_q  <= rst_cnt_d;
      rst_done_q <= rst_done_d;
    end
  end

  // Slot storage carries no reset; pointers alone define what is valid.
  always_ff @(posedge clkIn) begin
    if (wr_acc) begin
      for (int unsigned k = 0; k < RIN; k++) begin
        mem_q[PTR_W'(wr_ptr_q + PTR_W'(k))] <= fifoDataIn[k*MIN_W +: MIN_W];
      end
    end
  end

  assign fifoDataOutValid = (READMODE == 1) ? !empty_q : valid_q;
  assign fifoDataOut      = (READMODE == 1) ? (empty_q ? '0 : head_word) : dout_q;
  assign fifoRstDone      = rst_done_q;
  assign fifoEmpty        = empty_q;
  assign fifoFull         = full_q;
  assign fifoProgEmpty    = pempty_q;
  assign fifoProgFull     = pfull_q;
  assign fifoOverflow     = ovf_q;
  assign fifoUnderflow    = unf_q;
  assign fifoDataCount    = dcnt_q;

endmodule

// File: tb/tb_sync_width_fifo.sv
// Bench for sync_width_fifo: an 8->32 standard-read instance and an 8->8 FWFT instance,
// each checked against a byte-queue model with a negedge scoreboard monitor.
module tb_sync_width_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_we, a_re, a_valid, a_done, a_empty, a_full;
  logic        a_pempty, a_pfull, a_ovf, a_unf;
  logic [7:0]  a_din;
  logic [31:0] a_dout;
  logic [5:0]  a_count;

  logic        b_rst, b_we, b_re, b_valid, b_done, b_empty, b_full;
  logic        b_pempty, b_pfull, b_ovf, b_unf;
  logic [7:0]  b_din, b_dout;
  logic [7:0]  b_count;

  sync_width_fifo u_a (
    .clkIn(clk), .rstIn(a_rst), .fifoDataIn(a_din), .fifoWriteEn(a_we), .fifoReadEn(a_re),
    .fifoDataOut(a_dout), .fifoDataOutValid(a_valid), .fifoRstDone(a_done),
    .fifoEmpty(a_empty), .fifoFull(a_full), .fifoProgEmpty(a_pempty), .fifoProgFull(a_pfull),
    .fifoOverflow(a_ovf), .fifoUnderflow(a_unf), .fifoDataCount(a_count)
  );

  sync_width_fifo #(.DATAINWIDTH(8), .DATAOUTWIDTH(8), .MEMORYSIZE(1024), .READMODE(1)) u_b (
    .clkIn(clk), .rstIn(b_rst), .fifoDataIn(b_din), .fifoWriteEn(b_we), .fifoReadEn(b_re),
    .fifoDataOut(b_dout), .fifoDataOutValid(b_valid), .fifoRstDone(b_done),
    .fifoEmpty(b_empty), .fifoFull(b_full), .fifoProgEmpty(b_pempty), .fifoProgFull(b_pfull),
    .fifoOverflow(b_ovf), .fifoUnderflow(b_unf), .fifoDataCount(b_count)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [7:0]  bytes_a[$];
  logic [31:0] exp_a[$];
  logic [7:0]  bytes_b[$];
  int          a_edges = 0;
  int          b_edges = 0;
  logic [31:0] mon_w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard monitor: standard-mode words pop from exp_a, FWFT head is compared to the model.
  always @(negedge clk) begin
    if (a_valid) begin
      if (exp_a.size() == 0) check("a_valid_unexpected", 32'(a_valid), 32'd0);
      else begin
        mon_w = exp_a.pop_front();
        check("a_dout", a_dout, mon_w);
      end
    end
    if (b_valid) begin
      if (bytes_b.size() == 0) check("b_valid_unexpected", 32'(b_valid), 32'd0);
      else check("b_head", 32'(b_dout), 32'(bytes_b[0]));
    end
  end

  task automatic a_cycle(input bit we, input logic [7:0] d, input bit re);
    bit ready, full_m, empty_m, wacc, racc, ovf, unf;
    int n;
    a_we = we; a_din = d; a_re = re;
    ready   = (a_edges >= 2);
    full_m  = (bytes_a.size() >= 128);
    empty_m = (bytes_a.size() < 4);
    wacc = we && !full_m && ready;
    racc = re && !empty_m && ready;
    ovf  = we && full_m && ready;
    unf  = re && empty_m && ready;
    @(posedge clk);
    if (racc) begin
      exp_a.push_back({bytes_a[3], bytes_a[2], bytes_a[1], bytes_a[0]});
      repeat (4) void'(bytes_a.pop_front());
    end
    if (wacc) bytes_a.push_back(d);
    if (a_edges < 2) a_edges++;
    #1;
    n = bytes_a.size();
    check("a_rstdone", 32'(a_done), 32'(a_edges >= 2));
    check("a_valid", 32'(a_valid), 32'(racc));
    check("a_empty", 32'(a_empty), 32'(n < 4));
    check("a_full", 32'(a_full), 32'(n >= 128));
    check("a_count", 32'(a_count), 32'(n / 4));
    check("a_progempty", 32'(a_pempty), 32'((n / 4) <= 2));
    check("a_progfull", 32'(a_pfull), 32'(n >= 120));
    check("a_overflow", 32'(a_ovf), 32'(ovf));
    check("a_underflow", 32'(a_unf), 32'(unf));
  endtask

  task automatic a_reset();
    a_rst = 1'b1; a_we = 1'b1; a_re = 1'b1; a_din = 8'hEE;
    @(posedge clk);
    bytes_a.delete();
    exp_a.delete();
    a_edges = 0;
    #1;
    check("a_rst_done", 32'(a_done), 32'd0);
    check("a_rst_empty", 32'(a_empty), 32'd1);
    check("a_rst_count", 32'(a_count), 32'd0);
    check("a_rst_full", 32'(a_full), 32'd0);
    check("a_rst_pempty", 32'(a_pempty), 32'd1);
    check("a_rst_pfull", 32'(a_pfull), 32'd0);
    check("a_rst_flags", {30'd0, a_ovf, a_unf}, 32'd0);
    check("a_rst_valid", 32'(a_valid), 32'd0);
    check("a_rst_dout", a_dout, 32'd0);
    a_rst = 1'b0; a_we = 1'b0; a_re = 1'b0;
  endtask

  task automatic b_cycle(input bit we, input logic [7:0] d, input bit re);
    bit ready, wacc, pacc, ovf, unf;
    int n;
    b_we = we; b_din = d; b_re = re;
    ready = (b_edges >= 2);
    wacc = we && (bytes_b.size() < 128) && ready;
    pacc = re && (bytes_b.size() > 0) && ready;
    ovf  = we && (bytes_b.size() >= 128) && ready;
    unf  = re && (bytes_b.size() == 0) && ready;
    @(posedge clk);
    if (pacc) void'(bytes_b.pop_front());
    if (wacc) bytes_b.push_back(d);
    if (b_edges < 2) b_edges++;
    #1;
    n = bytes_b.size();
    check("b_rstdone", 32'(b_done), 32'(b_edges >= 2));
    check("b_valid", 32'(b_valid), 32'(n > 0));
    check("b_empty", 32'(b_empty), 32'(n == 0));
    check("b_full", 32'(b_full), 32'(n >= 128));
    check("b_count", 32'(b_count), 32'(n));
    check("b_progempty", 32'(b_pempty), 32'(n <= 2));
    check("b_progfull", 32'(b_pfull), 32'(n >= 120));
    check("b_overflow", 32'(b_ovf), 32'(ovf));
    check("b_underflow", 32'(b_unf), 32'(unf));
  endtask

  task automatic b_reset();
    b_rst = 1'b1; b_we = 1'b0; b_re = 1'b0; b_din = 8'h00;
    @(posedge clk);
    bytes_b.delete();
    b_edges = 0;
    #1;
    check("b_rst_valid", 32'(b_valid), 32'd0);
    check("b_rst_dout", 32'(b_dout), 32'd0);
    check("b_rst_empty", 32'(b_empty), 32'd1);
    b_rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit we, re;
    a_rst = 1'b1; a_we = 1'b0; a_re = 1'b0; a_din = 8'h00;
    b_rst = 1'b1; b_we = 1'b0; b_re = 1'b0; b_din = 8'h00;

    a_reset();
    a_cycle(0, 8'h00, 0);
    a_cycle(0, 8'h00, 0);

    // Underflow on empty: single-cycle pulse, nothing presented.
    a_cycle(0, 8'h00, 1);
    a_cycle(0, 8'h00, 0);

    // Packing order: first byte lands in the LSBs.
    a_cycle(1, 8'h11, 0);
    a_cycle(1, 8'h22, 0);
    a_cycle(1, 8'h33, 0);
    a_cycle(1, 8'h44, 0);
    a_cycle(0, 8'h00, 1);
    check("pack_word", a_dout, 32'h44332211);
    a_cycle(0, 8'h00, 0);

    // Fill to full, overflow once, then drain with a write racing the first read.
    repeat (128) a_cycle(1, 8'($urandom), 0);
    a_cycle(1, 8'hFF, 0);
    a_cycle(0, 8'h00, 0);
    a_cycle(1, 8'hFE, 1);
    while (bytes_a.size() >= 4) a_cycle(0, 8'h00, 1);
    a_cycle(0, 8'h00, 0);

    // Random concurrent traffic around 16 stored words; pointers wrap.
    repeat (64) a_cycle(1, 8'($urandom), 0);
    for (int i = 0; i < 300; i++) begin
      we = ($urandom_range(0, 3) != 0);
      re = (bytes_a.size() >= 64) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 5) == 0);
      a_cycle(we, 8'($urandom), re);
    end
    while (bytes_a.size() >= 4) a_cycle(0, 8'h00, 1);
    a_cycle(0, 8'h00, 0);

    // Mid-operation reset with 10 words stored; writes in the recovery window are dropped.
    while (bytes_a.size() < 40) a_cycle(1, 8'($urandom), 0);
    a_reset();
    a_cycle(1, 8'h5A, 0);
    a_cycle(1, 8'h5B, 0);
    repeat (4) a_cycle(1, 8'($urandom), 0);
    a_cycle(0, 8'h00, 1);
    a_cycle(0, 8'h00, 0);
    check("a_scoreboard_drained", 32'(exp_a.size()), 32'd0);

    // FWFT: data visible without a read, pop clears valid next cycle.
    b_reset();
    b_cycle(0, 8'h00, 0);
    b_cycle(0, 8'h00, 0);
    b_cycle(1, 8'hA5, 0);
    check("fwft_valid", 32'(b_valid), 32'd1);
    check("fwft_dout", 32'(b_dout), 32'hA5);
    b_cycle(0, 8'h00, 1);
    check("fwft_valid_after_pop", 32'(b_valid), 32'd0);
    b_cycle(0, 8'h00, 1);
    for (int i = 0; i < 400; i++) begin
      b_cycle($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 9) < 4);
    end
    while (bytes_b.size() > 0) b_cycle(0, 8'h00, 1);
    b_cycle(0, 8'h00, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sync_width_fifo.md
SYNC_WIDTH_FIFO -- requirements
Module: sync_width_fifo

Interface
REQ-001 The block SHALL have one clock and one synchronous, active-high reset, with the clock port named clkIn and the reset port named rstIn.
REQ-002 Parameter DATAINWIDTH, default 8: write word width in bits.
REQ-003 Parameter DATAOUTWIDTH, default 32: read word width in bits; the larger of DATAINWIDTH and DATAOUTWIDTH SHALL be an integer multiple of the smaller.
REQ-004 Parameter MEMORYSIZE, default 1024: storage in bits; derived DATAINDEPTH = MEMORYSIZE/DATAINWIDTH and DATAOUTDEPTH = MEMORYSIZE/DATAOUTWIDTH.
REQ-005 Parameter READMODE, default 0: 0 = standard read, 1 = first-word-fall-through (FWFT).
REQ-006 Parameter PROGFULLTHRESH, default DATAINDEPTH-8: programmable-full level in input words.
REQ-007 Parameter PROGEMPTYTHRESH, default 2: programmable-empty level in output words.
REQ-008 Ports, one per line:
- clkIn  in  1  clock
- rstIn  in  1  synchronous active-high reset
- fifoDataIn  in  DATAINWIDTH  write data
- fifoWriteEn  in  1  write request
- fifoReadEn  in  1  read request (FWFT: pop)
- fifoDataOut  out  DATAOUTWIDTH  read data
- fifoDataOutValid  out  1  fifoDataOut holds valid data
- fifoRstDone  out  1  high when the block is ready for traffic
- fifoEmpty / fifoFull  out  1 each  status
- fifoProgEmpty / fifoProgFull  out  1 each  threshold status
- fifoOverflow / fifoUnderflow  out  1 each  rejected-request pulses
- fifoDataCount  out  clog2(DATAOUTDEPTH)+1  whole output words stored

Function
REQ-009 Storage SHALL be organised in slots of min(DATAINWIDTH, DATAOUTWIDTH) bits; a write consumes RIN = DATAINWIDTH/min slots, a read consumes ROUT = DATAOUTWIDTH/min slots.
REQ-010 Packing (IN<OUT): the first written word SHALL occupy the LSBs of the output word. Unpacking (IN>OUT): the LSB slice SHALL be read first.
REQ-011 A write SHALL be accepted when fifoWriteEn=1, fifoFull=0 and fifoRstDone=1.
REQ-012 fifoFull SHALL be high when free slots < RIN; fifoEmpty SHALL be high when used slots < ROUT. Both flags are registered and derived from the post-update slot count.
REQ-013 Simultaneous accepted read and write SHALL leave the slot count changed by RIN-ROUT; a write on a full FIFO SHALL be rejected even if a read is accepted in the same cycle.
REQ-014 Standard mode: a read SHALL be accepted when fifoReadEn=1 and fifoEmpty=0; the data SHALL appear on fifoDataOut with fifoDataOutValid=1 exactly one cycle later, and fifoDataOut SHALL hold its value otherwise.
REQ-015 FWFT mode: fifoDataOutValid SHALL equal !fifoEmpty; fifoDataOut SHALL present the head word combinationally from registered state; fifoReadEn with valid=1 SHALL pop, and the next word SHALL be visible in the following cycle.
REQ-016 A rejected write SHALL raise fifoOverflow for one cycle in the cycle after the request; a read on empty SHALL raise fifoUnderflow likewise. Requests while fifoRstDone=0 SHALL be ignored without flagging.
REQ-017 fifoDataCount SHALL be floor(used slots / ROUT) and SHALL be registered.
REQ-018 fifoProgFull SHALL be high when used slots >= PROGFULLTHRESH*RIN; fifoProgEmpty SHALL be high when fifoDataCount <= PROGEMPTYTHRESH.
REQ-019 Read and write pointers SHALL wrap modulo the slot depth without loss of data or flag glitches.

Reset
REQ-020 With rstIn=1 sampled at clkIn: pointers and count = 0, fifoEmpty=1, fifoProgEmpty=1, fifoFull=0, fifoProgFull=0, fifoOverflow=0, fifoUnderflow=0, fifoDataOutValid=0, fifoDataOut=0, fifoRstDone=0.
REQ-021 fifoRstDone SHALL rise 2 cycles after rstIn is sampled low; a reset asserted mid-transfer SHALL discard all stored data and partial packs.

Verification
REQ-022 Packing with IN=8/OUT=32: write 0x11,0x22,0x33,0x44, then read -> fifoDataOut=0x44332211 with valid=1 one cycle after the read; count goes 1->0.
REQ-023 Fill test: 128 writes (IN=8, MEMORYSIZE=1024) -> fifoFull=1 after the 128th; a 129th write -> fifoOverflow pulses once and the data is unchanged on readback.
REQ-024 Underflow: read on empty after reset -> fifoUnderflow pulses for 1 cycle, valid stays 0, count stays 0.
REQ-025 FWFT with IN=OUT=8: write 0xA5 -> valid=1 and dout=0xA5 without a read; a pop -> valid=0 the next cycle.
REQ-026 Wrap and concurrency: 300 cycles of random simultaneous read and write at a count near 16 -> scoreboard order matches and the flags stay consistent with the count.
REQ-027 Mid-operation reset: assert rstIn with 10 words stored -> count=0 and empty=1 the next cycle, fifoRstDone=0 until 2 cycles after release, and writes during that window are ignored.
